// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the peripheral bus arbiter.
//   arb_state_e        : sequencer states IDLE / ACCESS / DONE
//   bus_req_t          : one master's latched bus request payload
//   BUS_ARB_ABORT_DATA : read data returned on a timed-out access
//   idx_w()            : width of a master index (at least 1 bit)
package bus_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HB_W   = 2;
    localparam int unsigned CE_W   = 8;

    localparam logic [DATA_W-1:0] BUS_ARB_ABORT_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic              re;
        logic [HB_W-1:0]   hb;
        logic [CE_W-1:0]   ce;
    } bus_req_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_rr_picker.sv
// Combinational round-robin picker: first requester at or above rr_ptr,
// searching upward with wrap.
//   req     : per-master request vector
//   rr_ptr  : highest-priority master index
//   valid_c : some master is requesting
//   idx_c   : selected master index (0 when valid_c is low)
module bus_rr_picker
    import bus_arb_pkg::*;
#(
    parameter  int unsigned NUM_MASTERS = 2,
    localparam int unsigned IDX_W       = idx_w(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       rr_ptr,
    output logic                   valid_c,
    output logic [IDX_W-1:0]       idx_c
);

    int unsigned cand;

    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        cand    = 0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (!valid_c && req[IDX_W'(cand)]) begin
                valid_c = 1'b1;
                idx_c   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and sequencer between memory-side masters and the
// shared peripheral bus. One registered transaction at a time; the owner
// receives a one-cycle grant with read data after the slave acknowledge.
// Optional feature macro: BUS_ARB_TIMEOUT_EN (abort ACCESS after
// TIMEOUT_CYCLES cycles without ack, grant with 32'hDEAD_BEEF, pulse o_TIMEOUT).
//   i_CLK, i_RST          : clock, synchronous active-high reset
//   i_M_*                 : packed per-master request fields (master k at slice k)
//   o_M_GNT, o_M_RDATA    : registered one-cycle grant and read data
//   o_BUS_*               : registered bus transaction
//   i_BUS_RDATA, i_BUS_ACK: slave read data and completion
//   o_TIMEOUT             : abort pulse (0 without the timeout feature)
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          i_CLK,
    input  logic                          i_RST,
    input  logic [NUM_MASTERS-1:0]        i_M_REQ,
    input  logic [ADDR_W*NUM_MASTERS-1:0] i_M_ADDR,
    input  logic [DATA_W*NUM_MASTERS-1:0] i_M_WDATA,
    input  logic [NUM_MASTERS-1:0]        i_M_WE,
    input  logic [NUM_MASTERS-1:0]        i_M_RE,
    input  logic [HB_W*NUM_MASTERS-1:0]   i_M_HB,
    input  logic [CE_W*NUM_MASTERS-1:0]   i_M_CE,
    output logic [NUM_MASTERS-1:0]        o_M_GNT,
    output logic [DATA_W-1:0]             o_M_RDATA,
    output logic [ADDR_W-1:0]             o_BUS_ADDR,
    output logic [DATA_W-1:0]             o_BUS_WDATA,
    output logic                          o_BUS_WE,
    output logic                          o_BUS_RE,
    output logic [HB_W-1:0]               o_BUS_HB,
    output logic [CE_W-1:0]               o_BUS_CE,
    input  logic [DATA_W-1:0]             i_BUS_RDATA,
    input  logic                          i_BUS_ACK,
    output logic                          o_TIMEOUT
);

    localparam int unsigned IDX_W = idx_w(NUM_MASTERS);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    bus_req_t               bus_q, bus_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;

    logic                   pick_valid_c;
    logic [IDX_W-1:0]       pick_idx_c;
    bus_req_t               sel_req_c;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;
`endif

    bus_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .req     (i_M_REQ),
        .rr_ptr  (rr_ptr_q),
        .valid_c (pick_valid_c),
        .idx_c   (pick_idx_c)
    );

    // Mux the picked master's request fields out of the packed buses.
    always_comb begin
        sel_req_c = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (IDX_W'(k) == pick_idx_c) begin
                sel_req_c.addr  = i_M_ADDR [k*ADDR_W +: ADDR_W];
                sel_req_c.wdata = i_M_WDATA[k*DATA_W +: DATA_W];
                sel_req_c.we    = i_M_WE[k];
                sel_req_c.re    = i_M_RE[k];
                sel_req_c.hb    = i_M_HB[k*HB_W +: HB_W];
                sel_req_c.ce    = i_M_CE[k*CE_W +: CE_W];
            end
        end
    end

    // Next-state and registered-output logic. Grant and read data default to
    // zero so they only pulse for the single DONE cycle.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        bus_d    = bus_q;
        gnt_d    = '0;
        rdata_d  = '0;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    state_d = ACCESS;
                    owner_d = pick_idx_c;
                    bus_d   = sel_req_c;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ACCESS: begin
                if (i_BUS_ACK) begin
                    state_d = DONE;
                    bus_d   = '0;
                    gnt_d   = NUM_MASTERS'(1) << owner_q;
                    rdata_d = bus_q.re ? i_BUS_RDATA : '0;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d   = DONE;
                    bus_d     = '0;
                    gnt_d     = NUM_MASTERS'(1) << owner_q;
                    rdata_d   = BUS_ARB_ABORT_DATA;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE: begin
                state_d  = IDLE;
                rr_ptr_d = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + IDX_W'(1);
            end
            default: begin
                state_d = IDLE;
                bus_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            bus_q    <= '0;
            gnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            bus_q    <= bus_d;
            gnt_q    <= gnt_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_TIMEOUT = timeout_q;
`else
    // Timeout configuration has no effect in this build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{32'(TIMEOUT_CYCLES), BUS_ARB_ABORT_DATA};
    assign o_TIMEOUT = 1'b0;
`endif

    assign o_M_GNT     = gnt_q;
    assign o_M_RDATA   = rdata_q;
    assign o_BUS_ADDR  = bus_q.addr;
    assign o_BUS_WDATA = bus_q.wdata;
    assign o_BUS_WE    = bus_q.we;
    assign o_BUS_RE    = bus_q.re;
    assign o_BUS_HB    = bus_q.hb;
    assign o_BUS_CE    = bus_q.ce;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues expected grants, a
// monitor pops and compares on every grant; a slave model acks after a
// programmable delay and returns o_BUS_ADDR ^ slave_key as read data.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req;
    logic [63:0] m_addr, m_wdata;
    logic [1:0]  m_we, m_re;
    logic [3:0]  m_hb;
    logic [15:0] m_ce;
    logic [1:0]  m_gnt;
    logic [31:0] m_rdata;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_we, bus_re, bus_ack, tout;
    logic [1:0]  bus_hb;
    logic [7:0]  bus_ce;

    bit          req_a [2];
    logic [31:0] addr_a [2];
    logic [31:0] wdata_a [2];
    bit          we_a [2];
    bit          re_a [2];
    logic [1:0]  hb_a [2];
    logic [7:0]  ce_a [2];

    assign m_req   = {req_a[1], req_a[0]};
    assign m_addr  = {addr_a[1], addr_a[0]};
    assign m_wdata = {wdata_a[1], wdata_a[0]};
    assign m_we    = {we_a[1], we_a[0]};
    assign m_re    = {re_a[1], re_a[0]};
    assign m_hb    = {hb_a[1], hb_a[0]};
    assign m_ce    = {ce_a[1], ce_a[0]};

    logic [31:0] slave_key = 32'h0;
    int          ack_delay = 0;
    bit          slave_en  = 1'b1;
    logic        slave_ack = 1'b0;
    logic        spur_ack  = 1'b0;
    int          wait_cnt  = 0;

    assign bus_ack   = slave_ack | spur_ack;
    assign bus_rdata = bus_addr ^ slave_key;

    bus_arbiter #(
        .NUM_MASTERS    (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_M_REQ     (m_req),
        .i_M_ADDR    (m_addr),
        .i_M_WDATA   (m_wdata),
        .i_M_WE      (m_we),
        .i_M_RE      (m_re),
        .i_M_HB      (m_hb),
        .i_M_CE      (m_ce),
        .o_M_GNT     (m_gnt),
        .o_M_RDATA   (m_rdata),
        .o_BUS_ADDR  (bus_addr),
        .o_BUS_WDATA (bus_wdata),
        .o_BUS_WE    (bus_we),
        .o_BUS_RE    (bus_re),
        .o_BUS_HB    (bus_hb),
        .o_BUS_CE    (bus_ce),
        .i_BUS_RDATA (bus_rdata),
        .i_BUS_ACK   (bus_ack),
        .o_TIMEOUT   (tout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  gnt;
        logic [31:0] rdata;
        logic        tout;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Slave: ack once the strobe has been visible for ack_delay extra cycles.
    always @(negedge clk) begin
        if (slave_en && (bus_re || bus_we)) begin
            if (wait_cnt >= ack_delay) begin
                slave_ack = 1'b1;
            end else begin
                slave_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            slave_ack = 1'b0;
            wait_cnt  = 0;
        end
    end

    // Monitor: every grant must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (m_gnt !== 2'b00) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_grant: got gnt=%b rdata=%h at cycle %0d, expected none",
                         m_gnt, m_rdata, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("grant_vec",     32'(m_gnt), 32'(e.gnt));
                chk("grant_rdata",   m_rdata,    e.rdata);
                chk("grant_timeout", 32'(tout),  32'(e.tout));
                chk("grant_cycle",   32'(cyc),   32'(e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input bit k, input bit req, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit we, input bit re,
                         input logic [1:0] hb, input logic [7:0] ce);
        req_a[k]   = req;
        addr_a[k]  = addr;
        wdata_a[k] = wdata;
        we_a[k]    = we;
        re_a[k]    = re;
        hb_a[k]    = hb;
        ce_a[k]    = ce;
    endtask

    task automatic clear_m(input bit k);
        set_m(k, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 8'h00);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0;
        rst = 1'b1;
        clear_m(1'b0);
        clear_m(1'b1);
        repeat (3) step();

        // Reset state
        @(negedge clk);
        chk("rst_bus_addr",  bus_addr,        32'h0);
        chk("rst_bus_wdata", bus_wdata,       32'h0);
        chk("rst_bus_we",    32'(bus_we),     32'h0);
        chk("rst_bus_re",    32'(bus_re),     32'h0);
        chk("rst_bus_hb",    32'(bus_hb),     32'h0);
        chk("rst_bus_ce",    32'(bus_ce),     32'h0);
        chk("rst_gnt",       32'(m_gnt),      32'h0);
        chk("rst_rdata",     m_rdata,         32'h0);
        chk("rst_timeout",   32'(tout),       32'h0);
        step();
        rst = 1'b0;
        repeat (2) step();

        // Single read by master 0, immediate ack
        slave_key = 32'hDAFE_0005;
        ack_delay = 0;
        set_m(1'b0, 1'b1, 32'h1000_0004, 32'h0, 1'b0, 1'b1, 2'b10, 8'h01);
        c0 = cyc;
        exp_q.push_back('{gnt: 2'b01, rdata: 32'hCAFE_0001, tout: 1'b0, cyc: c0 + 2});
        @(negedge clk);
        chk("rd_re_c0",   32'(bus_re), 32'h0);
        @(negedge clk);
        chk("rd_re_c1",   32'(bus_re), 32'h1);
        chk("rd_addr_c1", bus_addr,    32'h1000_0004);
        chk("rd_ce_c1",   32'(bus_ce), 32'h01);
        chk("rd_hb_c1",   32'(bus_hb), 32'h2);
        @(negedge clk);
        chk("rd_re_c2",   32'(bus_re), 32'h0);
        step();
        clear_m(1'b0);
        repeat (3) step();

        // Contention from reset: grants 0,1,0,1 at cycles 2,5,8,11
        do_reset(2);
        slave_key = 32'hA5A5_0000;
        set_m(1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 2'b00, 8'h02);
        set_m(1'b1, 1'b1, 32'h0000_0200, 32'h0, 1'b0, 1'b1, 2'b01, 8'h04);
        c0 = cyc;
        exp_q.push_back('{gnt: 2'b01, rdata: 32'hA5A5_0100, tout: 1'b0, cyc: c0 + 2});
        exp_q.push_back('{gnt: 2'b10, rdata: 32'hA5A5_0200, tout: 1'b0, cyc: c0 + 5});
        exp_q.push_back('{gnt: 2'b01, rdata: 32'hA5A5_0100, tout: 1'b0, cyc: c0 + 8});
        exp_q.push_back('{gnt: 2'b10, rdata: 32'hA5A5_0200, tout: 1'b0, cyc: c0 + 11});
        repeat (12) step();
        clear_m(1'b0);
        clear_m(1'b1);
        repeat (2) step();

        // Master 1 write with 4 wait states
        ack_delay = 4;
        set_m(1'b1, 1'b1, 32'h2000_0000, 32'h0000_0055, 1'b1, 1'b0, 2'b00, 8'h01);
        c0 = cyc;
        exp_q.push_back('{gnt: 2'b10, rdata: 32'h0, tout: 1'b0, cyc: c0 + 6});
        @(negedge clk);
        chk("wr_we_c0", 32'(bus_we), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk("wr_we_held",    32'(bus_we), 32'h1);
            chk("wr_wdata_held", bus_wdata,   32'h0000_0055);
        end
        @(negedge clk);
        chk("wr_we_c6", 32'(bus_we), 32'h0);
        step();
        clear_m(1'b1);
        ack_delay = 0;
        repeat (2) step();

        // Spurious ack while idle, then a normal read
        spur_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("spur_no_gnt",   32'(m_gnt),  32'h0);
            chk("spur_bus_idle", 32'(bus_re), 32'h0);
        end
        step();
        spur_ack  = 1'b0;
        slave_key = 32'h0;
        set_m(1'b0, 1'b1, 32'h3000_0000, 32'h0, 1'b0, 1'b1, 2'b00, 8'h08);
        c0 = cyc;
        exp_q.push_back('{gnt: 2'b01, rdata: 32'h3000_0000, tout: 1'b0, cyc: c0 + 2});
        repeat (3) step();
        clear_m(1'b0);
        repeat (2) step();

        // Reset during ACCESS: bus released, no grant, pointer back to 0
        ack_delay = 20;
        set_m(1'b1, 1'b1, 32'h4000_0000, 32'h0, 1'b0, 1'b1, 2'b01, 8'h10);
        @(negedge clk);
        @(negedge clk);
        chk("ra_re_access", 32'(bus_re), 32'h1);
        step();
        rst = 1'b1;
        clear_m(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("ra_bus_addr", bus_addr,     32'h0);
        chk("ra_bus_re",   32'(bus_re),  32'h0);
        chk("ra_bus_ce",   32'(bus_ce),  32'h0);
        chk("ra_gnt",      32'(m_gnt),   32'h0);
        step();
        rst = 1'b0;
        ack_delay = 0;
        repeat (3) step();
        set_m(1'b0, 1'b1, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 2'b00, 8'h01);
        set_m(1'b1, 1'b1, 32'h0000_0200, 32'h0, 1'b0, 1'b1, 2'b00, 8'h02);
        c0 = cyc;
        exp_q.push_back('{gnt: 2'b01, rdata: 32'h0000_0100, tout: 1'b0, cyc: c0 + 2});
        repeat (3) step();
        clear_m(1'b0);
        clear_m(1'b1);
        repeat (3) step();

`ifdef BUS_ARB_TIMEOUT_EN
        // No ack: abort 9 cycles after ACCESS entry
        slave_en = 1'b0;
        set_m(1'b0, 1'b1, 32'h5000_0000, 32'h0, 1'b0, 1'b1, 2'b00, 8'h01);
        c0 = cyc;
        exp_q.push_back('{gnt: 2'b01, rdata: 32'hDEAD_BEEF, tout: 1'b1, cyc: c0 + 10});
        repeat (11) step();
        clear_m(1'b0);
        slave_en = 1'b1;
        repeat (3) step();
`endif

        chk("exp_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
